// File: rtl/sdc_read_sequencer_pkg.sv
// Shared types and constants for the SD-card block read sequencer:
// FSM states, SD controller register map, command words and status decoding.
package sdc_seq_pkg;

    typedef enum logic [4:0] {
        S_IDLE,
        S_W_BLKCNT,
        S_W_DMA,
        S_W_CMD,
        S_W_ARG,
        S_WAIT_CMD,
        S_R_CSTAT,
        S_C_CSTAT,
        S_WAIT_DATA,
        S_R_DSTAT,
        S_C_DSTAT,
        S_W_CMD12,
        S_W_ARG12,
        S_WAIT_CMD12,
        S_R_CSTAT12,
        S_C_CSTAT12,
        S_DONE
    } seq_state_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_ZERO_CNT = 3'd1,
        ERR_CMD      = 3'd2,
        ERR_DATA     = 3'd3,
        ERR_TIMEOUT  = 3'd4,
        ERR_STOP     = 3'd5
    } err_code_e;

    localparam logic [7:0] REG_ARG       = 8'h00;
    localparam logic [7:0] REG_CMD       = 8'h04;
    localparam logic [7:0] REG_CMD_STAT  = 8'h34;
    localparam logic [7:0] REG_DATA_STAT = 8'h3C;
    localparam logic [7:0] REG_BLKCNT    = 8'h48;
    localparam logic [7:0] REG_DMA_ADDR  = 8'h60;

    // Command word: index in [5:0], bit 8 = response expected, bit 9 = data phase
    localparam logic [31:0] CMD_READ_SINGLE = 32'h0000_0311;
    localparam logic [31:0] CMD_READ_MULTI  = 32'h0000_0312;
    localparam logic [31:0] CMD_STOP        = 32'h0000_010C;

    localparam logic [31:0] STAT_ERR_MASK = 32'h0000_001E;

    function automatic logic stat_has_error(input logic [31:0] stat);
        return |(stat & STAT_ERR_MASK);
    endfunction

    function automatic logic is_wait_state(input seq_state_e s);
        return (s == S_WAIT_CMD) || (s == S_WAIT_DATA) || (s == S_WAIT_CMD12);
    endfunction

endpackage

// File: rtl/sdc_read_sequencer_if.sv
// Avalon-MM connection between the sequencer (master) and the SD controller slave port.
interface sdc_read_sequencer_if;

    logic [7:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  byteenable;
    logic        write;
    logic        read;
    logic        chipselect;
    logic        waitrequest_n;

    modport master (
        output address, writedata, byteenable, write, read, chipselect,
        input  readdata, waitrequest_n
    );

    modport slave (
        input  address, writedata, byteenable, write, read, chipselect,
        output readdata, waitrequest_n
    );

endinterface

// File: rtl/sdc_read_sequencer_avm_port.sv
// Single-access Avalon master: takes a held request from the FSM, runs one bus
// transfer through waitrequest and returns a one-cycle ack with the read data.
module sdc_seq_avm_port (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req,
    input  logic                        we,
    input  logic [7:0]                  addr,
    input  logic [31:0]                 wdata,
    output logic                        ack,
    output logic [31:0]                 rdata,
    sdc_read_sequencer_if.master        bus
);

    logic        active;
    logic        we_q;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;

    // A request held across the ack cycle is not re-launched: active drops first,
    // so the strobes go low for at least one cycle between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (active) begin
            if (bus.waitrequest_n) begin
                active <= 1'b0;
            end
        end else if (req) begin
            active  <= 1'b1;
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    assign bus.chipselect = active;
    assign bus.write      = active & we_q;
    assign bus.read       = active & ~we_q;
    assign bus.address    = addr_q;
    assign bus.writedata  = wdata_q;
    assign bus.byteenable = 4'hF;

    assign ack   = active & bus.waitrequest_n;
    assign rdata = bus.readdata;

endmodule

// File: rtl/sdc_read_sequencer.sv
// Reads N 512-byte blocks from the SD card into memory by programming the SD
// controller directly, waiting on its interrupts, clearing status and retrying.
module sdc_read_sequencer
    import sdc_seq_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000,
    parameter int          RETRIES     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [31:0]          blk_addr_i,
    input  logic [15:0]          blk_cnt_i,
    input  logic [31:0]          dst_addr_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [2:0]           err_code_o,
    input  logic                 int_cmd_i,
    input  logic                 int_data_i,
    sdc_read_sequencer_if.master avm
);

    localparam logic [23:0] TMO_LAST  = TIMEOUT_CYC - 24'd1;
    localparam logic [7:0]  RETRY_MAX = 8'(RETRIES);

    seq_state_e  state_q, state_d;
    logic [31:0] blk_addr_q;
    logic [15:0] blk_cnt_q;
    logic [31:0] dst_q;
    logic [7:0]  retry_q, retry_d;
    logic [23:0] tmo_q;
    logic        stat_err_q;
    logic [2:0]  err_code_q, err_code_d;
    logic        latch;

    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    sdc_seq_avm_port u_port (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ack   (ack),
        .rdata (rdata),
        .bus   (avm)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            blk_addr_q <= '0;
            blk_cnt_q  <= '0;
            dst_q      <= '0;
            retry_q    <= '0;
            tmo_q      <= '0;
            stat_err_q <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            err_code_q <= err_code_d;
            if (latch) begin
                blk_addr_q <= blk_addr_i;
                blk_cnt_q  <= blk_cnt_i;
                dst_q      <= dst_addr_i;
            end
            if (!is_wait_state(state_q)) begin
                tmo_q <= '0;
            end else if (tmo_q != '1) begin
                tmo_q <= tmo_q + 24'd1;
            end
            if (ack && (state_q == S_R_CSTAT || state_q == S_R_DSTAT || state_q == S_R_CSTAT12)) begin
                stat_err_q <= stat_has_error(rdata);
            end
        end
    end

    // Each bus state holds its request until the port acks; status errors from
    // the command or data phase restart the whole launch while retries remain.
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        err_code_d = err_code_q;
        latch      = 1'b0;
        req        = 1'b0;
        we         = 1'b0;
        addr       = REG_ARG;
        wdata      = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    latch   = 1'b1;
                    retry_d = '0;
                    if (blk_cnt_i == 16'd0) begin
                        state_d    = S_DONE;
                        err_code_d = ERR_ZERO_CNT;
                    end else begin
                        state_d    = S_W_BLKCNT;
                        err_code_d = ERR_NONE;
                    end
                end
            end
            S_W_BLKCNT: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = REG_BLKCNT;
                wdata = {16'h0000, blk_cnt_q - 16'd1};
                if (ack) state_d = S_W_DMA;
            end
            S_W_DMA: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = REG_DMA_ADDR;
                wdata = dst_q;
                if (ack) state_d = S_W_CMD;
            end
            S_W_CMD: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = REG_CMD;
                wdata = (blk_cnt_q == 16'd1) ? CMD_READ_SINGLE : CMD_READ_MULTI;
                if (ack) state_d = S_W_ARG;
            end
            S_W_ARG: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = REG_ARG;
                wdata = blk_addr_q;
                if (ack) state_d = S_WAIT_CMD;
            end
            S_WAIT_CMD: begin
                if (int_cmd_i) begin
                    state_d = S_R_CSTAT;
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = S_DONE;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            S_R_CSTAT: begin
                req  = 1'b1;
                addr = REG_CMD_STAT;
                if (ack) state_d = S_C_CSTAT;
            end
            S_C_CSTAT: begin
                req  = 1'b1;
                we   = 1'b1;
                addr = REG_CMD_STAT;
                if (ack) begin
                    if (!stat_err_q) begin
                        state_d = S_WAIT_DATA;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 8'd1;
                        state_d = S_W_BLKCNT;
                    end else begin
                        state_d    = S_DONE;
                        err_code_d = ERR_CMD;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (int_data_i) begin
                    state_d = S_R_DSTAT;
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = S_DONE;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            S_R_DSTAT: begin
                req  = 1'b1;
                addr = REG_DATA_STAT;
                if (ack) state_d = S_C_DSTAT;
            end
            S_C_DSTAT: begin
                req  = 1'b1;
                we   = 1'b1;
                addr = REG_DATA_STAT;
                if (ack) begin
                    if (stat_err_q) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 8'd1;
                            state_d = S_W_BLKCNT;
                        end else begin
                            state_d    = S_DONE;
                            err_code_d = ERR_DATA;
                        end
                    end else if (blk_cnt_q != 16'd1) begin
                        state_d = S_W_CMD12;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_W_CMD12: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = REG_CMD;
                wdata = CMD_STOP;
                if (ack) state_d = S_W_ARG12;
            end
            S_W_ARG12: begin
                req  = 1'b1;
                we   = 1'b1;
                addr = REG_ARG;
                if (ack) state_d = S_WAIT_CMD12;
            end
            S_WAIT_CMD12: begin
                if (int_cmd_i) begin
                    state_d = S_R_CSTAT12;
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = S_DONE;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            S_R_CSTAT12: begin
                req  = 1'b1;
                addr = REG_CMD_STAT;
                if (ack) state_d = S_C_CSTAT12;
            end
            S_C_CSTAT12: begin
                req  = 1'b1;
                we   = 1'b1;
                addr = REG_CMD_STAT;
                if (ack) begin
                    state_d = S_DONE;
                    if (stat_err_q) err_code_d = ERR_STOP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o     = (state_q == S_DONE);
    assign err_code_o = err_code_q;
    assign err_o      = (err_code_q != ERR_NONE);

endmodule

// File: tb/tb_sdc_read_sequencer.sv
// Directed bench for sdc_read_sequencer with a behavioural SD controller slave
// that logs register writes, stretches accesses and raises interrupts.
module tb_sdc_read_sequencer;

    localparam logic [7:0]  A_ARG    = 8'h00;
    localparam logic [7:0]  A_CMD    = 8'h04;
    localparam logic [7:0]  A_CSTAT  = 8'h34;
    localparam logic [7:0]  A_DSTAT  = 8'h3C;
    localparam logic [7:0]  A_BLKCNT = 8'h48;
    localparam logic [7:0]  A_DMA    = 8'h60;
    localparam logic [31:0] W_CMD17  = 32'h0000_0311;
    localparam logic [31:0] W_CMD18  = 32'h0000_0312;
    localparam logic [31:0] W_CMD12  = 32'h0000_010C;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] blk_addr_i = '0;
    logic [15:0] blk_cnt_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic        busy_o, done_o, err_o;
    logic [2:0]  err_code_o;
    logic        int_cmd = 1'b0;
    logic        int_data = 1'b0;

    int total = 0;
    int bad = 0;

    // slave model state
    int          wait_n = 0;
    int          int_delay = 50;
    logic        data_never = 1'b0;
    logic        stall_en = 1'b0;
    logic [7:0]  stall_addr = 8'h00;
    logic [31:0] cstat_val = 32'h1;
    logic [31:0] dstat_tab [3] = '{32'h1, 32'h1, 32'h1};
    logic [31:0] dstat_val = 32'h1;
    logic [31:0] last_cmd = '0;
    int          wait_ctr = 0;
    int          cmd_cd = -1;
    int          data_cd = -1;
    int          launches = 0;
    int          launch_base = 0;
    int          stop_launches = 0;
    int          dclears = 0;
    int          cyc = 0;
    int          cclr_cyc = 0;
    int          rw_viol = 0;
    logic [7:0]  wlog_addr [$];
    logic [31:0] wlog_data [$];

    always #5 clk_i = ~clk_i;

    sdc_read_sequencer_if avm ();

    sdc_read_sequencer #(.TIMEOUT_CYC(24'd100), .RETRIES(2)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .blk_addr_i (blk_addr_i),
        .blk_cnt_i  (blk_cnt_i),
        .dst_addr_i (dst_addr_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .int_cmd_i  (int_cmd),
        .int_data_i (int_data),
        .avm        (avm)
    );

    assign avm.waitrequest_n = avm.chipselect && (wait_ctr >= wait_n) &&
                               !(stall_en && (avm.address == stall_addr));
    assign avm.readdata = (avm.address == A_CSTAT) ? cstat_val :
                          (avm.address == A_DSTAT) ? dstat_val : 32'h0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) if (avm.read && avm.write) rw_viol <= rw_viol + 1;

    // Slave: writes to ARG launch a command; interrupts follow after int_delay
    // cycles and are cleared by writing the matching status register.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_ctr <= 0;
        end else begin
            if (cmd_cd > 0) cmd_cd <= cmd_cd - 1;
            else if (cmd_cd == 0) begin int_cmd <= 1'b1; cmd_cd <= -1; end
            if (data_cd > 0) data_cd <= data_cd - 1;
            else if (data_cd == 0) begin int_data <= 1'b1; data_cd <= -1; end
            if (avm.chipselect && !avm.waitrequest_n) wait_ctr <= wait_ctr + 1;
            if (avm.chipselect && avm.waitrequest_n) begin
                wait_ctr <= 0;
                if (avm.write) begin
                    wlog_addr.push_back(avm.address);
                    wlog_data.push_back(avm.writedata);
                    case (avm.address)
                        A_CMD: last_cmd <= avm.writedata;
                        A_ARG: begin
                            cmd_cd <= int_delay;
                            if (last_cmd == W_CMD12) begin
                                stop_launches <= stop_launches + 1;
                            end else begin
                                launches  <= launches + 1;
                                dstat_val <= dstat_tab[((launches - launch_base) > 2) ? 2 : (launches - launch_base)];
                                if (!data_never) data_cd <= int_delay + 10;
                            end
                        end
                        A_CSTAT: begin int_cmd <= 1'b0; cclr_cyc <= cyc; end
                        A_DSTAT: begin int_data <= 1'b0; dclears <= dclears + 1; end
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] cnt, input logic [31:0] baddr, input logic [31:0] daddr);
        @(negedge clk_i);
        blk_cnt_i  = cnt;
        blk_addr_i = baddr;
        dst_addr_i = daddr;
        start_i    = 1'b1;
        @(negedge clk_i);
        start_i    = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!done_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
    endtask

    task automatic checkDone(input string tag, input logic [2:0] code);
        checkOutput({tag, "_done"}, 32'(done_o), 32'd1);
        checkOutput({tag, "_busy_in_done"}, 32'(busy_o), 32'd0);
        checkOutput({tag, "_code"}, 32'(err_code_o), 32'(code));
        checkOutput({tag, "_err"}, 32'(err_o), 32'(code != 3'd0));
        @(negedge clk_i);
        checkOutput({tag, "_done_1cyc"}, 32'(done_o), 32'd0);
    endtask

    task automatic checkWrite(input string tag, input int idx, input logic [7:0] a, input logic [31:0] d);
        logic [7:0]  oa = 8'hFF;
        logic [31:0] od = 32'hDEAD_BEEF;
        if (idx < wlog_addr.size()) begin
            oa = wlog_addr[idx];
            od = wlog_data[idx];
        end
        checkOutput({tag, "_addr"}, 32'(oa), 32'(a));
        checkOutput({tag, "_data"}, od, d);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int wb, lb, sb, db, diff;

        repeat (3) @(negedge clk_i);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_done", 32'(done_o), 32'd0);
        checkOutput("rst_err_code", 32'(err_code_o), 32'd0);
        checkOutput("rst_cs", 32'(avm.chipselect), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // single block read, two wait states per access
        wait_n = 2; int_delay = 50;
        wb = wlog_addr.size(); lb = launches; launch_base = launches;
        applyStimulus(16'd1, 32'h1000, 32'h8000);
        checkOutput("t1_busy", 32'(busy_o), 32'd1);
        waitDone(2000);
        checkDone("t1", 3'd0);
        checkOutput("t1_nwrites", 32'(wlog_addr.size() - wb), 32'd6);
        checkWrite("t1_w0", wb + 0, A_BLKCNT, 32'h0);
        checkWrite("t1_w1", wb + 1, A_DMA, 32'h8000);
        checkWrite("t1_w2", wb + 2, A_CMD, W_CMD17);
        checkWrite("t1_w3", wb + 3, A_ARG, 32'h1000);
        checkWrite("t1_w4", wb + 4, A_CSTAT, 32'h0);
        checkWrite("t1_w5", wb + 5, A_DSTAT, 32'h0);

        // multi-block read followed by CMD12
        wait_n = 1;
        wb = wlog_addr.size(); sb = stop_launches; launch_base = launches;
        applyStimulus(16'd4, 32'h2000, 32'h9000);
        waitDone(2000);
        checkDone("t2", 3'd0);
        checkOutput("t2_nwrites", 32'(wlog_addr.size() - wb), 32'd9);
        checkWrite("t2_w0", wb + 0, A_BLKCNT, 32'h3);
        checkWrite("t2_w2", wb + 2, A_CMD, W_CMD18);
        checkWrite("t2_w3", wb + 3, A_ARG, 32'h2000);
        checkWrite("t2_w6", wb + 6, A_CMD, W_CMD12);
        checkWrite("t2_w7", wb + 7, A_ARG, 32'h0);
        checkWrite("t2_w8", wb + 8, A_CSTAT, 32'h0);
        checkOutput("t2_stops", 32'(stop_launches - sb), 32'd1);

        // data error twice then success
        wait_n = 0;
        dstat_tab = '{32'h5, 32'h5, 32'h1};
        wb = wlog_addr.size(); lb = launches; db = dclears; launch_base = launches;
        applyStimulus(16'd1, 32'h40, 32'h100);
        waitDone(3000);
        checkDone("t3a", 3'd0);
        checkOutput("t3a_launches", 32'(launches - lb), 32'd3);
        checkOutput("t3a_dclears", 32'(dclears - db), 32'd3);
        checkOutput("t3a_nwrites", 32'(wlog_addr.size() - wb), 32'd18);

        // data error on every attempt
        dstat_tab = '{32'h5, 32'h5, 32'h5};
        lb = launches; db = dclears; launch_base = launches;
        applyStimulus(16'd1, 32'h40, 32'h100);
        waitDone(3000);
        checkDone("t3b", 3'd3);
        checkOutput("t3b_launches", 32'(launches - lb), 32'd3);
        checkOutput("t3b_dclears", 32'(dclears - db), 32'd3);

        // data interrupt never arrives: WAIT_DATA entered at the CMD_STAT clear edge,
        // counter reaches 99 after 99 more edges and DONE is entered on the 100th
        dstat_tab = '{32'h1, 32'h1, 32'h1};
        data_never = 1'b1;
        lb = launches; db = dclears; launch_base = launches;
        applyStimulus(16'd1, 32'h77, 32'h200);
        waitDone(1000);
        diff = cyc - cclr_cyc;
        checkDone("t4", 3'd4);
        checkOutput("t4_tmo_cycles", 32'(diff), 32'd101);
        checkOutput("t4_launches", 32'(launches - lb), 32'd1);
        checkOutput("t4_dclears", 32'(dclears - db), 32'd0);
        data_never = 1'b0;

        // zero block count
        wb = wlog_addr.size();
        applyStimulus(16'd0, 32'h55, 32'h300);
        checkDone("t5z", 3'd1);
        checkOutput("t5z_nwrites", 32'(wlog_addr.size() - wb), 32'd0);
        checkOutput("t5z_busy_after", 32'(busy_o), 32'd0);

        // start pulses while busy are ignored
        wb = wlog_addr.size(); lb = launches; launch_base = launches;
        applyStimulus(16'd1, 32'h3000, 32'hA000);
        for (int k = 0; k < 3; k++) begin
            repeat (5) @(negedge clk_i);
            blk_cnt_i = 16'd4;
            start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
        end
        waitDone(2000);
        checkOutput("t5_done", 32'(done_o), 32'd1);
        checkOutput("t5_code", 32'(err_code_o), 32'd0);
        checkOutput("t5_nwrites", 32'(wlog_addr.size() - wb), 32'd6);
        checkWrite("t5_w0", wb + 0, A_BLKCNT, 32'h0);
        checkOutput("t5_launches", 32'(launches - lb), 32'd1);
        // start asserted during the DONE cycle is not accepted
        blk_cnt_i = 16'd1;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        checkOutput("t5_done_start_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        checkOutput("t5_done_start_idle", 32'(busy_o), 32'd0);
        checkOutput("t5_done_start_nwrites", 32'(wlog_addr.size() - wb), 32'd6);

        // async reset while the CMD write is stalled
        wait_n = 0; stall_en = 1'b1; stall_addr = A_CMD;
        applyStimulus(16'd1, 32'h5000, 32'hB000);
        begin
            int n = 0;
            while (!(avm.chipselect && avm.address == A_CMD) && n < 200) begin
                @(negedge clk_i);
                n++;
            end
        end
        checkOutput("t6_stalled_cs", 32'(avm.chipselect), 32'd1);
        repeat (2) @(negedge clk_i);
        checkOutput("t6_held_write", 32'(avm.write), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("t6_rst_write", 32'(avm.write), 32'd0);
        checkOutput("t6_rst_read", 32'(avm.read), 32'd0);
        checkOutput("t6_rst_cs", 32'(avm.chipselect), 32'd0);
        checkOutput("t6_rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        stall_en = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i);
        wb = wlog_addr.size(); lb = launches; launch_base = launches;
        applyStimulus(16'd1, 32'h6000, 32'hC000);
        waitDone(2000);
        checkDone("t6", 3'd0);
        checkOutput("t6_nwrites", 32'(wlog_addr.size() - wb), 32'd6);
        checkWrite("t6_w3", wb + 3, A_ARG, 32'h6000);
        checkOutput("t6_launches", 32'(launches - lb), 32'd1);

        checkOutput("no_rw_overlap", 32'(rw_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
